// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: valid/ready operand and result bundle for serial_subtractor
interface serial_subtractor_if #(parameter int WIDTH = 4);
    logic             in_valid, in_ready, bin, out_valid, out_ready, bout;
    logic [WIDTH-1:0] a, b, d;
    modport master(output in_valid, a, b, bin, out_ready, input in_ready, out_valid, d, bout);
    modport slave(input in_valid, a, b, bin, out_ready, output in_ready, out_valid, d, bout);
endinterface

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b - bin, LSB first, one full-subtractor cell
module serial_subtractor #(
    parameter int WIDTH = 4,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input logic clk,
    input logic rst,
    serial_subtractor_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_n;
    logic [WIDTH-1:0] a_sr, b_sr, d_sr;
    logic [CNT_W-1:0] cnt;
    logic borrow, diff, borrow_n, last, x, y;
    // state register
    always_ff @(posedge clk)
        state <= rst ? IDLE : state_n;
    // next state and handshake outputs decoded from state only
    always_comb begin
        last = cnt == CNT_W'(WIDTH - 1);
        state_n = (state == IDLE && bus.in_valid) ? RUN :
                  (state == RUN && last) ? DONE :
                  (state == DONE && bus.out_ready) ? IDLE : state;
        bus.in_ready = state == IDLE;
        bus.out_valid = state == DONE;
    end
    // full-subtractor cell on the current LSBs
    always_comb begin
        x = a_sr[0];
        y = b_sr[0];
        diff = x ^ y ^ borrow;
        borrow_n = (~x & y) | (~(x ^ y) & borrow);
    end
    // operand capture, serial shift, borrow flop and bit counter
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr <= '0;
            b_sr <= '0;
            d_sr <= '0;
            borrow <= 1'b0;
            cnt <= '0;
        end else if (state == IDLE && bus.in_valid) begin
            a_sr <= bus.a;
            b_sr <= bus.b;
            borrow <= bus.bin;
            cnt <= '0;
        end else if (state == RUN) begin
            a_sr <= a_sr >> 1;
            b_sr <= b_sr >> 1;
            d_sr <= WIDTH'({diff, d_sr} >> 1);
            borrow <= borrow_n;
            cnt <= cnt + CNT_W'(1);
        end
    end
    assign bus.d = d_sr;
    assign bus.bout = borrow;
endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial subtractor, WIDTH bits. Computes d = a - b - bin.
- Uses a single full-subtractor cell and a borrow flop, processing one bit per clock, LSB first.
- It is the inverse-direction companion to the ripple-carry adder chain: the same arithmetic role with much less area, in exchange for multi-cycle latency.
- Connects to producers and consumers through a valid/ready handshake on both sides.

Parameters:
- WIDTH, 4, operand/result width in bits (must be >= 1).
- CNT_W, $clog2(WIDTH+1), width of the internal bit counter (derived; do not override).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  operands a, b, bin are valid
- in_ready  output  1  block can accept operands
- a  input  WIDTH  minuend
- b  input  WIDTH  subtrahend
- bin  input  1  borrow-in
- out_valid  output  1  d, bout are valid
- out_ready  input  1  consumer accepts the result
- d  output  WIDTH  difference, a - b - bin (mod 2^WIDTH)
- bout  output  1  borrow-out: 1 iff a < b + bin (unsigned)

Behaviour:
- Single clock domain. rst is synchronous and active-high; it overrides every other input.
- Reset state:
  - FSM in IDLE.
  - in_ready = 1, out_valid = 0, d = 0, bout = 0.
  - Internal shift registers and counter = 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1, out_valid = 0.
  - When in_valid && in_ready at a rising edge, capture a -> A_sr, b -> B_sr, bin -> borrow, counter = 0, and go to RUN.
- RUN:
  - in_ready = 0, out_valid = 0.
  - Each cycle uses x = A_sr[0], y = B_sr[0], br = borrow:
    - diff bit = x ^ y ^ br
    - borrow_next = (~x & y) | (~(x ^ y) & br)
  - Shift A_sr and B_sr right by 1. Shift the diff bit into the MSB of D_sr (right shift), and register borrow_next.
  - Increment the counter. On the edge where the counter reaches WIDTH-1 (i.e. WIDTH RUN cycles), go to DONE.
  - At that same edge, D_sr holds the full result and the borrow flop holds bout.
- DONE:
  - out_valid = 1, in_ready = 0.
  - d and bout are driven directly from registers and held stable until out_valid && out_ready.
  - On that handshake edge, go to IDLE. d and bout keep their value; they are don't-care once out_valid = 0.
- Latency: out_valid rises exactly WIDTH cycles after the input-accept edge.
  - Throughput is one operation per WIDTH+2 cycles when out_ready is held at 1.
- Boundary conditions:
  - in_valid while in RUN or DONE is ignored; the operands are not sampled.
  - out_ready while in IDLE or RUN has no effect.
  - No same-cycle input accept while in DONE: in_ready is 0 there, so a new accept cannot occur earlier than the cycle after the output handshake.
  - Changing a, b or bin after the accept edge has no effect on the result.
  - rst asserted in RUN or DONE: on the next edge the FSM returns to IDLE with the reset values. The in-flight operation is discarded and no out_valid pulse is produced.
  - WIDTH = 1: RUN lasts exactly 1 cycle.
  - Wrap-around: d is modulo 2^WIDTH and there is no overflow flag (unsigned semantics; bout indicates underflow).
- All outputs are registered or decoded from the state register only. There are no combinational paths from in_valid/out_ready to outputs other than the state decode.

Test Plan:
1. WIDTH=4. After reset, check in_ready=1, out_valid=0, d=0, bout=0. Then accept a=9, b=3, bin=0 -> out_valid rises 4 cycles after accept with d=4'h6, bout=0.
2. WIDTH=4, a=3, b=9, bin=0 -> d=4'hA, bout=1. Also a=0, b=0, bin=1 -> d=4'hF, bout=1. Also a=4'hF, b=4'hF, bin=0 -> d=0, bout=0.
3. Back-pressure: hold out_ready=0 for 10 cycles after out_valid -> d and bout stay stable, in_ready stays 0, and in_valid with new operands is ignored. Then raise out_ready -> IDLE next cycle, and a following op (a=7, b=2) gives d=5.
4. Reset mid-operation: accept a=12, b=5, assert rst two cycles into RUN -> the next edge shows IDLE/reset values, no out_valid pulse follows, and a subsequent op a=1, b=1 gives d=0, bout=0.
5. Operand change after accept: accept a=10, b=4, then drive a=0, b=15 during RUN -> the result is still d=6, bout=0.
6. WIDTH=8 and WIDTH=1 builds, 1000 random ops with random out_ready stalls -> each {bout,d} equals ((a - b - bin) mod 2^(WIDTH+1)) from the reference model, with latency exactly WIDTH cycles.
